// File: rtl/gf180mcu_osu_sc_12t_scan_ctrl.sv
// rtl/gf180mcu_osu_sc_12t_scan_ctrl.sv - scan chain load/capture/unload sequencer
// Drives SE/SI/CAP of a CHAIN_LEN flop chain and returns the unloaded word on a VALID/RREADY port.
module gf180mcu_osu_sc_12t_scan_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ,
    input  logic                 MODE,
    input  logic [CHAIN_LEN-1:0] WDATA,
    output logic                 ACK,
    output logic                 BUSY,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO,
    output logic                 CAP,
    output logic [CHAIN_LEN-1:0] RDATA,
    output logic                 VALID,
    input  logic                 RREADY
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        CAPTURE   = 3'd2,
        SHIFT_OUT = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state;
    logic [CHAIN_LEN-1:0] sr;
    logic [CNT_W-1:0]     cnt;
    logic                 mode_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
            ACK    <= 1'b0;
            BUSY   <= 1'b0;
            SE     <= 1'b0;
            SI     <= 1'b0;
            CAP    <= 1'b0;
            RDATA  <= '0;
            VALID  <= 1'b0;
        end else begin
            ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ) begin
                        ACK    <= 1'b1;
                        BUSY   <= 1'b1;
                        sr     <= WDATA;
                        mode_q <= MODE;
                        cnt    <= '0;
                        state  <= SHIFT_IN;
                    end
                end
                SHIFT_IN: begin
                    // The ACK cycle is spent here with SE low; it stages bit 0 onto SI.
                    if (!SE) begin
                        SE <= 1'b1;
                        SI <= sr[0];
                        sr <= sr >> 1;
                    end else begin
                        RDATA <= {SO, RDATA[CHAIN_LEN-1:1]};
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            SE <= 1'b0;
                            SI <= 1'b0;
                            if (mode_q) begin
                                CAP   <= 1'b1;
                                state <= CAPTURE;
                            end else begin
                                VALID <= 1'b1;
                                state <= DONE;
                            end
                        end else begin
                            SI <= sr[0];
                            sr <= sr >> 1;
                        end
                    end
                end
                CAPTURE: begin
                    CAP   <= 1'b0;
                    cnt   <= '0;
                    SE    <= 1'b1;
                    SI    <= 1'b0;
                    state <= SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    RDATA <= {SO, RDATA[CHAIN_LEN-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        SE    <= 1'b0;
                        VALID <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (RREADY) begin
                        VALID <= 1'b0;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_scan_ctrl.sv
// tb/tb_gf180mcu_osu_sc_12t_scan_ctrl.sv - bench for the scan chain sequencer
// A 16-flop chain model sits on SE/SI/SO/CAP; expected words go through a scoreboard queue.
module tb_gf180mcu_osu_sc_12t_scan_ctrl;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst, req, mode, rready;
    logic [N-1:0] wdata;
    logic         ack, busy, se, si, so, cap, valid;
    logic [N-1:0] rdata;

    logic [N-1:0] chain = '0;
    bit           so_stuck = 1'b0;
    logic [N-1:0] sb[$];

    int passed = 0;
    int total  = 0;

    int ack_cyc, ack_cnt, se_cnt, se_first, se_last, cap_cyc, cap_cnt, valid_cyc;
    bit se_during_cap;
    logic [N-1:0] si_word, got;

    gf180mcu_osu_sc_12t_scan_ctrl #(.CHAIN_LEN(N)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .MODE(mode), .WDATA(wdata),
        .ACK(ack), .BUSY(busy), .SE(se), .SI(si), .SO(so), .CAP(cap),
        .RDATA(rdata), .VALID(valid), .RREADY(rready)
    );

    always #5 clk = ~clk;

    // Capture inverts the whole bank; shifting moves SI into element 0.
    always @(posedge clk) begin
        if (cap)     chain <= ~chain;
        else if (se) chain <= {chain[N-2:0], si};
    end
    assign so = so_stuck ? 1'b1 : chain[N-1];

    function automatic logic [N-1:0] rev(input logic [N-1:0] x);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = x[N-1-i];
        return r;
    endfunction

    task automatic do_op(input logic m, input logic [N-1:0] w, input logic [N-1:0] exp, input bit poke);
        bit done = 0;
        logic [N-1:0] e;
        ack_cyc = -1; ack_cnt = 0; se_cnt = 0; se_first = -1; se_last = -1;
        cap_cyc = -1; cap_cnt = 0; se_during_cap = 0; valid_cyc = -1; si_word = '0;
        sb.push_back(exp);
        mode = m; wdata = w; req = 1'b1; rready = 1'b0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = c;
                req = 1'b0;
            end
            if (se) begin
                if (se_cnt < N) si_word[se_cnt] = si;
                se_cnt++;
                if (se_first < 0) se_first = c;
                se_last = c;
            end
            if (poke) req = se && (se_cnt == 3);
            if (cap) begin
                cap_cnt++;
                cap_cyc = c;
                if (se) se_during_cap = 1;
            end
            if (valid) begin
                valid_cyc = c;
                got = rdata;
                done = 1;
            end
        end
        req = 1'b0;
        total++;
        if (!done) begin
            $display("FAIL op_timeout: valid=%0b after 200 cycles, required 1", valid);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if (got !== e) $display("FAIL scoreboard_rdata: got %h required %h", got, e);
            else passed++;
        end
    endtask

    task automatic test_reset();
        bit ok = 1;
        int n = 0;
        rst = 1'b1; req = 1'b0; mode = 1'b0; wdata = '0; rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ack, busy, se, si, cap, valid, rdata} !== '0)
            $display("FAIL reset_outputs: ack=%b busy=%b se=%b si=%b cap=%b valid=%b rdata=%h, required all 0",
                     ack, busy, se, si, cap, valid, rdata);
        else passed++;
        rst = 1'b0;
        req = 1'b1; wdata = 16'hFFFF;
        for (int c = 0; c < 50 && n < 5; c++) begin
            @(posedge clk); #1;
            if (ack) req = 1'b0;
            if (se) n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (se !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || cap !== 1'b0)
            $display("FAIL reset_mid_shift: se=%b busy=%b valid=%b cap=%b, required 0 0 0 0 (se count %0d)",
                     se, busy, valid, cap, n);
        else passed++;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || ack !== 1'b0) ok = 0;
        end
        total++;
        if (!ok) $display("FAIL reset_stays_idle: busy=%b ack=%b, required 0 0", busy, ack);
        else passed++;
    endtask

    task automatic test_mode0();
        do_op(1'b0, 16'hA5C3, rev(chain), 0);
        total++;
        if (ack_cyc !== 1 || ack_cnt !== 1)
            $display("FAIL m0_ack: cycle %0d count %0d, required 1 1", ack_cyc, ack_cnt);
        else passed++;
        total++;
        if (se_cnt !== N || se_first !== 2 || se_last !== N + 1)
            $display("FAIL m0_se_window: count %0d first %0d last %0d, required %0d 2 %0d", se_cnt, se_first, se_last, N, N + 1);
        else passed++;
        total++;
        if (valid_cyc !== N + 2 || cap_cnt !== 0)
            $display("FAIL m0_valid_latency: valid %0d caps %0d, required %0d 0", valid_cyc, cap_cnt, N + 2);
        else passed++;
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
        do_op(1'b0, 16'h0000, 16'hA5C3, 0);
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
        total++;
        if (valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL m0_release: valid=%b busy=%b, required 0 0", valid, busy);
        else passed++;
    endtask

    task automatic test_mode1();
        do_op(1'b1, 16'h00FF, 16'hFF00, 0);
        total++;
        if (cap_cyc !== N + 2 || cap_cnt !== 1 || se_during_cap !== 0)
            $display("FAIL m1_capture: cycle %0d count %0d se_overlap %0b, required %0d 1 0", cap_cyc, cap_cnt, se_during_cap, N + 2);
        else passed++;
        total++;
        if (se_cnt !== 2 * N || se_last !== 2 * N + 2 || valid_cyc !== 2 * N + 3)
            $display("FAIL m1_latency: se %0d last %0d valid %0d, required %0d %0d %0d",
                     se_cnt, se_last, valid_cyc, 2 * N, 2 * N + 2, 2 * N + 3);
        else passed++;
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit stable = 1;
        bit no_ack = 1;
        do_op(1'b0, 16'h1234, rev(chain), 1);
        total++;
        if (ack_cnt !== 1) $display("FAIL bp_req_in_shift: ack count %0d, required 1", ack_cnt);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            req = (i == 3);
            @(posedge clk); #1;
            if (valid !== 1'b1 || rdata !== got || busy !== 1'b1) stable = 0;
            if (ack !== 1'b0) no_ack = 0;
        end
        req = 1'b0;
        total++;
        if (!stable) $display("FAIL bp_hold: valid=%b busy=%b rdata=%h, required 1 1 %h", valid, busy, rdata, got);
        else passed++;
        total++;
        if (!no_ack) $display("FAIL bp_req_in_done: ack seen, required none");
        else passed++;
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release: valid=%b busy=%b, required 0 0", valid, busy);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (ack !== 1'b0) $display("FAIL bp_no_late_ack: ack=%b, required 0", ack);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 2; m++) begin
            int acks[$];
            int pops = 0;
            bit overlap = 0;
            logic [N-1:0] w = (m == 0) ? 16'h3C3C : 16'h0F0F;
            logic [N-1:0] e;
            mode = m[0]; wdata = w; req = 1'b1; rready = 1'b1;
            for (int c = 0; c < 300 && pops < 3; c++) begin
                @(posedge clk); #1;
                if (ack && se) overlap = 1;
                if (ack) begin
                    acks.push_back(c);
                    sb.push_back(m == 0 ? rev(chain) : ~w);
                    if (acks.size() == 3) req = 1'b0;
                end
                if (valid) begin
                    pops++;
                    e = sb.pop_front();
                    total++;
                    if (rdata !== e) $display("FAIL b2b_rdata_m%0d: got %h required %h", m, rdata, e);
                    else passed++;
                end
            end
            req = 1'b0;
            @(posedge clk); #1;
            rready = 1'b0;
            total++;
            if (acks.size() !== 3 || pops !== 3) begin
                $display("FAIL b2b_count_m%0d: acks %0d results %0d, required 3 3", m, acks.size(), pops);
            end else if (acks[1] - acks[0] !== (m == 0 ? N + 3 : 2 * N + 4) ||
                         acks[2] - acks[1] !== (m == 0 ? N + 3 : 2 * N + 4)) begin
                $display("FAIL b2b_spacing_m%0d: %0d %0d, required %0d", m, acks[1] - acks[0],
                         acks[2] - acks[1], (m == 0 ? N + 3 : 2 * N + 4));
            end else passed++;
            total++;
            if (overlap) $display("FAIL b2b_se_overlap_m%0d: se high in ack cycle, required low", m);
            else passed++;
        end
    endtask

    task automatic test_serial();
        do_op(1'b0, 16'h5555, rev(chain), 0);
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
        total++;
        if (si_word !== 16'h5555) $display("FAIL serial_si_trace: got %h required 5555", si_word);
        else passed++;
        do_op(1'b0, 16'h0000, 16'h5555, 0);
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
        so_stuck = 1'b1;
        do_op(1'b0, 16'h0000, 16'hFFFF, 0);
        rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
        so_stuck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_backpressure();
        test_back_to_back();
        test_serial();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gf180mcu_osu_sc_12t_scan_ctrl.md
Name: gf180mcu_osu_sc_12T_scan_ctrl

Overview:
Sequencer that loads, captures and unloads a serial chain of CHAIN_LEN scan flip-flops built from the library DFF cells.
- Accepts a parallel word over a REQ/ACK handshake, shifts it into the chain LSB-first, and optionally pulses a one-cycle functional capture.
- Shifts the chain contents back out and presents them on a VALID/RREADY result port.
- Sits between a test/config host and a flop bank; it is the only driver of the bank's SE/SI/CAP controls.

Parameters:
CHAIN_LEN, 16, number of flops in the chain (2..64).
CNT_W, $clog2(CHAIN_LEN+1), width of the internal bit counter.

Ports:
CLK  input  1  clock; all state updates on posedge.
RST  input  1  synchronous active-high reset.
REQ  input  1  host request; sampled only in IDLE.
MODE  input  1  0 = shift-only (load and unload simultaneously), 1 = shift-in, capture, shift-out.
WDATA  input  CHAIN_LEN  word to load; sampled with REQ.
ACK  output  1  one-cycle pulse when a request is accepted.
BUSY  output  1  high in every state except IDLE.
SE  output  1  scan enable to the chain.
SI  output  1  serial data into chain element 0.
SO  input  1  serial data from chain element CHAIN_LEN-1.
CAP  output  1  one-cycle functional-capture enable to the flop bank.
RDATA  output  CHAIN_LEN  unloaded chain contents.
VALID  output  1  RDATA valid; held until RREADY.
RREADY  input  1  host consumes RDATA.

Behaviour:
- Reset (RST=1 at a posedge):
  - State goes to IDLE.
  - ACK=0, BUSY=0, SE=0, SI=0, CAP=0, VALID=0, RDATA=0.
  - Internal shift register and counter are cleared.
  - Reset overrides every other input in the same cycle, including mid-shift or mid-capture. Chain contents are then undefined.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - REQ=1 at an edge → ACK=1 for the next cycle.
  - Latch WDATA into the shift register and MODE into a mode flag; clear the counter; go to SHIFT_IN.
  - REQ in any other state is ignored: no ACK, no latch.
- SHIFT_IN (exactly CHAIN_LEN cycles):
  - SE=1; SI = shift register bit 0.
  - Each edge: shift register shifts right; RDATA shifts right with SO entering bit CHAIN_LEN-1; counter increments.
  - Result: RDATA[0] is the first SO sampled, i.e. the old element CHAIN_LEN-1.
  - When the counter reaches CHAIN_LEN: go to DONE if mode=0, else to CAPTURE.
- CAPTURE (1 cycle): SE=0, CAP=1, SI=0. Counter clears; go to SHIFT_OUT.
- SHIFT_OUT (CHAIN_LEN cycles): SE=1, SI=0, RDATA shifts in SO exactly as in SHIFT_IN; then go to DONE.
- DONE:
  - SE=0, VALID=1, RDATA stable.
  - RREADY=1 at an edge → VALID=0 next cycle, go to IDLE.
  - A REQ asserted in the same cycle is not accepted; it is accepted one cycle later in IDLE if still high.
- Latency, with ACK in cycle T:
  - Mode 0: SE high in cycles T+1..T+N; VALID first high in T+N+1.
  - Mode 1: CAP high in T+N+1; SE high in T+N+2..T+2N+1; VALID in T+2N+2.
- Control outputs (SE, SI, CAP, ACK, VALID, BUSY) are all registered; none is combinational from an input.
- Bit ordering guarantee: a mode-0 load of X followed by a mode-0 op returns RDATA == X exactly.
- The counter never wraps; CHAIN_LEN transfers per shift phase, exactly.

Test Plan:
1. Reset, then reset mid-operation:
   - RST high 2 cycles → all outputs 0.
   - Later, RST asserted during SHIFT_IN cycle 5 → next cycle IDLE, SE=0, BUSY=0, VALID=0.
2. Mode-0 round trip (CHAIN_LEN=16, bench chain model of 16 flops):
   - Load WDATA=0xA5C3 → ACK at T, SE high exactly 16 cycles, VALID at T+17.
   - Second mode-0 op with WDATA=0x0000 → RDATA=0xA5C3.
3. Mode-1 capture:
   - Chain model replaces its contents with the bitwise inverse on CAP.
   - Load 0x00FF → CAP exactly one cycle at T+17; SE low during CAP; VALID at T+34.
   - RDATA=0xFF00.
4. Handshake backpressure:
   - Hold RREADY=0 for 10 cycles in DONE → VALID and RDATA stable, BUSY=1.
   - REQ pulses during SHIFT_IN and during DONE produce no ACK.
   - Then RREADY=1 → VALID drops next cycle.
5. Back-to-back:
   - REQ held high continuously with RREADY tied high → successive ACKs separated by exactly N+3 cycles in mode 0 and 2N+4 in mode 1.
   - No SE overlap between operations.
6. Serial alternating pattern:
   - Load 0x5555 → SI toggles every shift cycle starting with 1.
   - Readback returns 0x5555.
   - A chain model with SO stuck at 1 yields RDATA=0xFFFF.
